// File: rtl/fft_seq_pkg.sv
// Shared definitions for the ping-pong FFT sequencer.
//  - seq_state_t : sequencer FSM encodings
//  - FMT_FP4/FMT_FP8 : format_mode values
//  - bitrev() : reverse the low w bits of a value (used by the optional
//    natural-order write path, FFT_SEQ_BITREV_EN)
package fft_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_SWAP,
        S_DONE
    } seq_state_t;

    localparam logic FMT_FP4 = 1'b0;
    localparam logic FMT_FP8 = 1'b1;

    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// Combinational radix-2 DIT address generator.
// Maps issue index idx and stage to the memory read address of one element of
// a butterfly pair, which element of the pair it is, and the pair's twiddle.
// Ports:
//  idx      in  ADDR_WIDTH    issue counter i (pair b = i>>1, element e = i[0])
//  stage    in  STAGE_W       current stage
//  rd_addr  out ADDR_WIDTH    (grp << (stage+1)) | pos | e*span
//  bf_elem  out 1             0 = top, 1 = bottom
//  tw_idx   out ADDR_WIDTH-1  pos << (LOG2N-1-stage)
module fft_bfly_addr_gen #(
    parameter int ADDR_WIDTH = 10,
    parameter int STAGE_W    = 4
) (
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [STAGE_W-1:0]    stage,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  bf_elem,
    output logic [ADDR_WIDTH-2:0] tw_idx
);

    logic [ADDR_WIDTH-2:0] b;
    logic [ADDR_WIDTH-2:0] pos;
    logic [ADDR_WIDTH-2:0] grp;
    logic [ADDR_WIDTH-2:0] mask;
    logic [ADDR_WIDTH-1:0] span;
    logic [STAGE_W:0]      stage_p1;
    logic [STAGE_W:0]      tw_sh;

    always_comb begin
        b        = idx[ADDR_WIDTH-1:1];
        bf_elem  = idx[0];
        span     = ADDR_WIDTH'(1) << stage;
        // On the last stage span's low bits are all zero, so the subtraction
        // wraps to an all-ones mask, which is exactly span-1 there.
        mask     = span[ADDR_WIDTH-2:0] - (ADDR_WIDTH-1)'(1);
        pos      = b & mask;
        grp      = b >> stage;
        stage_p1 = {1'b0, stage} + (STAGE_W+1)'(1);
        tw_sh    = (STAGE_W+1)'(ADDR_WIDTH-1) - {1'b0, stage};
        rd_addr  = ({1'b0, grp} << stage_p1) | {1'b0, pos} | (bf_elem ? span : '0);
        tw_idx   = pos << tw_sh;
    end

endmodule

// File: rtl/fft_pingpong_sequencer.sv
// Initiator for the ping-pong FFT working memory. Runs LOG2N in-place radix-2
// DIT stages: each stage issues N reads from bank_sel, the external butterfly
// writes results D = 1+BF_LAT cycles later to the other bank, then bank_sel
// swaps. Write data never passes through this block.
// Ports:
//  clk, rst                 clock / async active-high reset
//  start, fmt_sel           run request (IDLE only) and format, latched on start
//  busy, done               run in progress / one-cycle completion pulse
//  bank_sel, format_mode    read-bank select, latched format
//  rd_addr                  read address (0 outside ISSUE)
//  rd_data_valid, bf_elem,
//  tw_idx, stage            side-band for the data on rd_data (issue + 1 cycle)
//  wr_en, wr_addr           write strobe/address (issue + D cycles)
// Build option: FFT_SEQ_BITREV_EN -- final-stage writes go to the bit-reversed
// address so the result lands in natural order.
module fft_pingpong_sequencer
    import fft_seq_pkg::*;
#(
    parameter int N          = 1024,
    parameter int ADDR_WIDTH = $clog2(N),
    parameter int BF_LAT     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          fmt_sel,
    output logic                          busy,
    output logic                          done,
    output logic                          bank_sel,
    output logic                          format_mode,
    output logic [ADDR_WIDTH-1:0]         rd_addr,
    output logic                          rd_data_valid,
    output logic                          bf_elem,
    output logic [ADDR_WIDTH-2:0]         tw_idx,
    output logic [$clog2(ADDR_WIDTH)-1:0] stage,
    output logic                          wr_en,
    output logic [ADDR_WIDTH-1:0]         wr_addr
);

    localparam int LOG2N   = ADDR_WIDTH;
    localparam int D       = 1 + BF_LAT;
    localparam int STAGE_W = $clog2(ADDR_WIDTH);
    localparam int DCW     = $clog2(D + 1);

    seq_state_t            state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DCW-1:0]        dcnt;
    logic                  issue;

    logic [ADDR_WIDTH-1:0] gen_addr;
    logic                  gen_elem;
    logic [ADDR_WIDTH-2:0] gen_tw;
    logic [ADDR_WIDTH-1:0] wa_in;

    logic [D:1]                 vld_pipe;
    logic [D:1][ADDR_WIDTH-1:0] wa_pipe;

    fft_bfly_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STAGE_W    (STAGE_W)
    ) u_addr_gen (
        .idx     (cnt),
        .stage   (stage),
        .rd_addr (gen_addr),
        .bf_elem (gen_elem),
        .tw_idx  (gen_tw)
    );

    assign issue   = (state == S_ISSUE);
    assign rd_addr = issue ? gen_addr : '0;

`ifdef FFT_SEQ_BITREV_EN
    assign wa_in = (stage == STAGE_W'(LOG2N - 1))
                   ? ADDR_WIDTH'(bitrev(32'(rd_addr), ADDR_WIDTH)) : rd_addr;
`else
    assign wa_in = rd_addr;
`endif

    // Sequencer FSM: IDLE -> (ISSUE -> DRAIN -> SWAP) x LOG2N -> DONE -> IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            dcnt        <= '0;
            stage       <= '0;
            bank_sel    <= 1'b0;
            format_mode <= FMT_FP4;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_ISSUE;
                        cnt         <= '0;
                        stage       <= '0;
                        format_mode <= fmt_sel;
                        busy        <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (cnt == ADDR_WIDTH'(N - 1)) begin
                        state <= S_DRAIN;
                        cnt   <= '0;
                        dcnt  <= '0;
                    end else begin
                        cnt <= cnt + ADDR_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    // Hold off the bank swap until the last write of the stage
                    // has left the D-deep pipe.
                    if (dcnt == DCW'(D - 1)) state <= S_SWAP;
                    else                     dcnt  <= dcnt + DCW'(1);
                end
                S_SWAP: begin
                    bank_sel <= ~bank_sel;
                    if (stage == STAGE_W'(LOG2N - 1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        stage <= stage + STAGE_W'(1);
                        state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    stage <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Side-band (1 cycle) and write (D cycles) delay lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            wa_pipe  <= '0;
            bf_elem  <= 1'b0;
            tw_idx   <= '0;
        end else begin
            vld_pipe[1] <= issue;
            wa_pipe[1]  <= wa_in;
            bf_elem     <= issue ? gen_elem : 1'b0;
            tw_idx      <= issue ? gen_tw : '0;
            for (int k = 2; k <= D; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                wa_pipe[k]  <= wa_pipe[k-1];
            end
        end
    end

    assign rd_data_valid = vld_pipe[1];
    assign wr_en         = vld_pipe[D];
    assign wr_addr       = wa_pipe[D];

endmodule

// File: tb/tb_fft_pingpong_sequencer.sv
// Scoreboard bench for fft_pingpong_sequencer at N=8, BF_LAT=2 (D=3).
// Expected reads/writes are queued when a run is started and compared as the
// DUT presents rd_data_valid / wr_en.
module tb_fft_pingpong_sequencer;
    import fft_seq_pkg::*;

    localparam int N     = 8;
    localparam int AW    = 3;
    localparam int LOG2N = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          fmt_sel = 1'b0;
    logic          busy, done, bank_sel, format_mode;
    logic [AW-1:0] rd_addr;
    logic          rd_data_valid, bf_elem;
    logic [AW-2:0] tw_idx;
    logic [1:0]    stage;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    fft_pingpong_sequencer #(.N(N), .BF_LAT(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .fmt_sel       (fmt_sel),
        .busy          (busy),
        .done          (done),
        .bank_sel      (bank_sel),
        .format_mode   (format_mode),
        .rd_addr       (rd_addr),
        .rd_data_valid (rd_data_valid),
        .bf_elem       (bf_elem),
        .tw_idx        (tw_idx),
        .stage         (stage),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int elem;
        int tw;
        int bank;
        int stg;
        int fmt;
    } rd_exp_t;

    rd_exp_t rq[$];
    int      wq[$];
    rd_exp_t cur;
    int      wcur;
    int      prev_rd = 0;
    int      bank_exp = 0;
    int      n_chk = 0;
    int      n_fail = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int brev3(input int a);
        return ((a & 1) << 2) | (a & 2) | ((a >> 2) & 1);
    endfunction

    function automatic int exp_wa(input int a, input int s);
`ifdef FFT_SEQ_BITREV_EN
        if (s == LOG2N - 1) return brev3(a);
`endif
        return a;
    endfunction

    // Reference ordering: pairs walked group-major, position-minor.
    task automatic push_run(input int fmt);
        for (int s = 0; s < LOG2N; s++) begin
            int span = 1 << s;
            for (int g = 0; g < N / (2 * span); g++) begin
                for (int p = 0; p < span; p++) begin
                    int top = g * 2 * span + p;
                    int tw  = p * (N / (2 * span));
                    rq.push_back('{top, 0, tw, bank_exp ^ (s & 1), s, fmt});
                    rq.push_back('{top + span, 1, tw, bank_exp ^ (s & 1), s, fmt});
                    wq.push_back(exp_wa(top, s));
                    wq.push_back(exp_wa(top + span, s));
                end
            end
        end
        bank_exp = bank_exp ^ (LOG2N & 1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_data_valid) begin
                if (rq.size() == 0) chk("rd_extra", 1, 0);
                else begin
                    cur = rq.pop_front();
                    chk("rd_addr", prev_rd, cur.addr);
                    chk("bf_elem", int'(bf_elem), cur.elem);
                    chk("tw_idx", int'(tw_idx), cur.tw);
                    chk("bank_sel", int'(bank_sel), cur.bank);
                    chk("stage", int'(stage), cur.stg);
                    chk("format_mode", int'(format_mode), cur.fmt);
                end
            end
            if (wr_en) begin
                if (wq.size() == 0) chk("wr_extra", 1, 0);
                else begin
                    wcur = wq.pop_front();
                    chk("wr_addr", int'(wr_addr), wcur);
                end
            end
        end
        prev_rd = rst ? 0 : int'(rd_addr);
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_bank"}, int'(bank_sel), 0);
        chk({tag, "_fmt"}, int'(format_mode), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_rdv"}, int'(rd_data_valid), 0);
        chk({tag, "_tw"}, int'(tw_idx), 0);
        chk({tag, "_stage"}, int'(stage), 0);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    endtask

    task automatic wait_done(input bit pulse, input logic fmt, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (pulse) begin
                start   = (n == 4 || n == 9);
                fmt_sel = ~fmt;
            end
        end while (!done && n < 200);
        if (pulse) start = 1'b0;
    endtask

    task automatic run_single(input logic fmt, input bit pulse);
        int n;
        @(negedge clk);
        start = 1'b1; fmt_sel = fmt;
        push_run(int'(fmt));
        @(negedge clk);
        start = 1'b0; fmt_sel = ~fmt;
        chk("busy_after_start", int'(busy), 1);
        wait_done(pulse, fmt, n);
        chk("run_cycles", n + 1, 37);
        chk("busy_at_done", int'(busy), 1);
        chk("bank_at_done", int'(bank_sel), bank_exp);
        @(negedge clk);
        chk("busy_after_done", int'(busy), 0);
        chk("done_pulse_len", int'(done), 0);
        chk("rq_empty", rq.size(), 0);
        chk("wq_empty", wq.size(), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        #1;
        check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("idle");

        // fp8 run with stray start pulses during ISSUE and DRAIN
        run_single(FMT_FP8, 1'b1);

        // start held high: two back-to-back runs
        @(negedge clk);
        start = 1'b1; fmt_sel = FMT_FP4;
        push_run(int'(FMT_FP4));
        @(negedge clk);
        wait_done(1'b0, FMT_FP4, n);
        chk("b2b_first", n + 1, 37);
        push_run(int'(FMT_FP4));
        wait_done(1'b0, FMT_FP4, n);
        chk("b2b_second", n, 38);
        chk("b2b_bank", int'(bank_sel), bank_exp);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_rq_empty", rq.size(), 0);
        chk("b2b_wq_empty", wq.size(), 0);
        chk("b2b_idle", int'(busy), 0);

        // reset in the middle of stage 1 ISSUE
        @(negedge clk);
        start = 1'b1; fmt_sel = FMT_FP8;
        push_run(int'(FMT_FP8));
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (stage != 2'd1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_stage1", int'(stage), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        rq.delete();
        wq.delete();
        bank_exp = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_idle", int'(busy), 0);

        // clean run after the abort
        run_single(FMT_FP8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
